// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: N GPR write lanes plus HI/LO, with stall/bubble/flush,
// r0 write suppression, WB-stage forwarding lookup and a saturating retire counter.

module mem_wb_lane #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] fwd_raddr,
    output logic              wreg_ld,
    output logic              hit
);
    assign wreg_ld = mem_wreg & mem_valid & (mem_wd != '0);
    assign hit     = wb_wreg & (wb_wd == fwd_raddr) & (fwd_raddr != '0);
endmodule

module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_mem,
    input  logic                     stall_wb,
    input  logic                     flush,
    input  logic                     mem_valid,
    input  logic [LANES*ADDR_W-1:0]  mem_wd,
    input  logic [LANES-1:0]         mem_wreg,
    input  logic [LANES*DATA_W-1:0]  mem_wdata,
    input  logic                     mem_whilo,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     cnt_clr,
    input  logic [ADDR_W-1:0]        fwd_raddr,
    output logic                     wb_valid,
    output logic [LANES*ADDR_W-1:0]  wb_wd,
    output logic [LANES-1:0]         wb_wreg,
    output logic [LANES*DATA_W-1:0]  wb_wdata,
    output logic                     wb_whilo,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [CNT_W-1:0]         retire_cnt
);
    logic [LANES-1:0][ADDR_W-1:0] mem_wd_a, wd_q, wd_d;
    logic [LANES-1:0][DATA_W-1:0] mem_wdata_a, wdata_q, wdata_d;
    logic [LANES-1:0]             wreg_q, wreg_d, wreg_ld, lane_hit;
    logic                         valid_q, valid_d, whilo_q, whilo_d;
    logic [DATA_W-1:0]            hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         bubble, load;

    assign mem_wd_a    = mem_wd;
    assign mem_wdata_a = mem_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            mem_wb_lane #(.ADDR_W(ADDR_W)) u_lane (
                .mem_wd    (mem_wd_a[gi]),
                .mem_wreg  (mem_wreg[gi]),
                .mem_valid (mem_valid),
                .wb_wd     (wd_q[gi]),
                .wb_wreg   (wreg_q[gi]),
                .fwd_raddr (fwd_raddr),
                .wreg_ld   (wreg_ld[gi]),
                .hit       (lane_hit[gi])
            );
        end
    endgenerate

    // Flush dominates; a MEM stall with WB free drains the stage with a bubble.
    assign bubble = flush | (stall_mem & ~stall_wb);
    assign load   = ~bubble & ~stall_mem;

    always_comb begin
        valid_d = valid_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (bubble) begin
            valid_d = 1'b0;
            wd_d    = '0;
            wreg_d  = '0;
            wdata_d = '0;
            whilo_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
        end else if (load) begin
            valid_d = mem_valid;
            wd_d    = mem_wd_a;
            wreg_d  = wreg_ld;
            wdata_d = mem_wdata_a;
            whilo_d = mem_whilo & mem_valid;
            hi_d    = mem_hi;
            lo_d    = mem_lo;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (load && mem_valid && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ascending scan so the highest-index hitting lane wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_hit[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = wdata_q[i];
            end
        end
    end

    assign wb_valid   = valid_q;
    assign wb_wd      = wd_q;
    assign wb_wreg    = wreg_q;
    assign wb_wdata   = wdata_q;
    assign wb_whilo   = whilo_q;
    assign wb_hi      = hi_q;
    assign wb_lo      = lo_q;
    assign retire_cnt = cnt_q;
endmodule
